// File: rtl/adc_apb_sampler_pkg.sv
// Shared definitions for the ADC APB sampler and the ADC slave wrapper:
// FSM encodings, error codes and the default ADC register map.
package adc_apb_sampler_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_AMUX,
        S_W_TRIG,
        S_R_STAT,
        S_GAP,
        S_R_MEAS
    } state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_ACCESS
    } phase_e;

    localparam logic [1:0] ERR_SLVERR  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam int STATUS_DONE_BIT = 0;

    localparam logic [11:0] DEF_STATUS_ADDR = 12'h000;
    localparam logic [11:0] DEF_MEAS_ADDR   = 12'h004;
    localparam logic [11:0] DEF_AMUX_ADDR   = 12'h00C;
    localparam logic [11:0] DEF_TRIG_ADDR   = 12'h010;

endpackage

// File: rtl/adc_apb_sampler_if.sv
// APB bus bundle between the sampler (master) and the ADC peripheral (slave).
interface adc_apb_sampler_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/adc_apb_sampler_apb_master_port.sv
// Single-transfer APB master: turns a level request into SETUP/ACCESS phases,
// waits out PREADY and reports completion with read data and slave error.
module apb_master_port
    import adc_apb_sampler_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  write_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  slverr_o,
    adc_apb_sampler_if.master     apb
);

    phase_e                phase_q, phase_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        phase_d = phase_q;
        done_o  = 1'b0;
        unique case (phase_q)
            PH_IDLE:   if (req_i) phase_d = PH_SETUP;
            PH_SETUP:  phase_d = PH_ACCESS;
            PH_ACCESS: if (apb.PREADY) begin
                phase_d = PH_IDLE;
                done_o  = 1'b1;
            end
            default:   phase_d = PH_IDLE;
        endcase
    end

    // Request is captured only when idle, so the bus stays stable through wait states.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            phase_q <= PH_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            phase_q <= phase_d;
            if (phase_q == PH_IDLE && req_i) begin
                addr_q  <= addr_i;
                write_q <= write_i;
                wdata_q <= write_i ? wdata_i : '0;
            end
        end
    end

    assign apb.PSEL    = (phase_q != PH_IDLE);
    assign apb.PENABLE = (phase_q == PH_ACCESS);
    assign apb.PWRITE  = write_q;
    assign apb.PADDR   = addr_q;
    assign apb.PWDATA  = wdata_q;
    assign rdata_o     = apb.PRDATA;
    assign slverr_o    = apb.PSLVERR;

endmodule

// File: rtl/adc_apb_sampler.sv
// Autonomous ADC scanner: every sample period it selects the next AMUX channel,
// triggers a conversion, polls STATUS and reads the measurement over APB.
module adc_apb_sampler
    import adc_apb_sampler_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_CH      = 4,
    parameter int                    PERIOD_W    = 16,
    parameter int                    MAX_POLLS   = 64,
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(DEF_STATUS_ADDR),
    parameter logic [ADDR_WIDTH-1:0] MEAS_ADDR   = ADDR_WIDTH'(DEF_MEAS_ADDR),
    parameter logic [ADDR_WIDTH-1:0] AMUX_ADDR   = ADDR_WIDTH'(DEF_AMUX_ADDR),
    parameter logic [ADDR_WIDTH-1:0] TRIG_ADDR   = ADDR_WIDTH'(DEF_TRIG_ADDR)
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  enable,
    input  logic [PERIOD_W-1:0]   period,
    adc_apb_sampler_if.master     apb,
    output logic                  sample_valid,
    output logic [DATA_WIDTH-1:0] sample_data,
    output logic [3:0]            sample_ch,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic                  overrun,
    output logic                  busy
);

    localparam int POLL_W = $clog2(MAX_POLLS + 1);

    state_e                state_q, state_d;
    logic [PERIOD_W-1:0]   cnt_q, cnt_d;
    logic [3:0]            ch_q, ch_d;
    logic [POLL_W-1:0]     polls_q, polls_d;
    logic                  tick, seq_end;

    logic                  req, req_write, done, slverr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata, rdata;

    logic                  sample_valid_q, sample_valid_d;
    logic [DATA_WIDTH-1:0] sample_data_q, sample_data_d;
    logic [3:0]            sample_ch_q, sample_ch_d;
    logic                  err_q, err_d, overrun_q, overrun_d;
    logic [1:0]            err_code_q, err_code_d;

    // Period timer: held at the reload value while disabled.
    always_comb begin
        tick = enable && (cnt_q == '0);
        if (!enable || tick) cnt_d = period;
        else                 cnt_d = cnt_q - 1'b1;
    end

    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        polls_d        = polls_q;
        seq_end        = 1'b0;
        req            = 1'b0;
        req_addr       = '0;
        req_write      = 1'b0;
        req_wdata      = '0;
        sample_valid_d = 1'b0;
        sample_data_d  = sample_data_q;
        sample_ch_d    = sample_ch_q;
        err_d          = 1'b0;
        err_code_d     = err_code_q;
        overrun_d      = tick && (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: if (tick) begin
                state_d = S_W_AMUX;
                polls_d = '0;
            end
            S_W_AMUX: begin
                req       = 1'b1;
                req_addr  = AMUX_ADDR;
                req_write = 1'b1;
                req_wdata = DATA_WIDTH'(ch_q);
                if (done) state_d = S_W_TRIG;
            end
            S_W_TRIG: begin
                req       = 1'b1;
                req_addr  = TRIG_ADDR;
                req_write = 1'b1;
                req_wdata = DATA_WIDTH'(1);
                if (done) state_d = S_R_STAT;
            end
            S_R_STAT: begin
                req      = 1'b1;
                req_addr = STATUS_ADDR;
                if (done) begin
                    if (rdata[STATUS_DONE_BIT]) begin
                        state_d = S_R_MEAS;
                    end else if (polls_q == POLL_W'(MAX_POLLS - 1)) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                        seq_end    = 1'b1;
                    end else begin
                        polls_d = polls_q + 1'b1;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: state_d = S_R_STAT;
            S_R_MEAS: begin
                req      = 1'b1;
                req_addr = MEAS_ADDR;
                if (done) begin
                    sample_valid_d = 1'b1;
                    sample_data_d  = rdata;
                    sample_ch_d    = ch_q;
                    seq_end        = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A slave error on any completing access overrides whatever the state decided.
        if (done && slverr) begin
            sample_valid_d = 1'b0;
            sample_data_d  = sample_data_q;
            sample_ch_d    = sample_ch_q;
            err_d          = 1'b1;
            err_code_d     = ERR_SLVERR;
            seq_end        = 1'b1;
        end

        if (seq_end) begin
            state_d = S_IDLE;
            ch_d    = (ch_q == 4'(NUM_CH - 1)) ? 4'd0 : ch_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            ch_q           <= '0;
            polls_q        <= '0;
            sample_valid_q <= 1'b0;
            sample_data_q  <= '0;
            sample_ch_q    <= '0;
            err_q          <= 1'b0;
            err_code_q     <= '0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ch_q           <= ch_d;
            polls_q        <= polls_d;
            sample_valid_q <= sample_valid_d;
            sample_data_q  <= sample_data_d;
            sample_ch_q    <= sample_ch_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
            overrun_q      <= overrun_d;
        end
    end

    apb_master_port #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_port (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .req_i    (req),
        .addr_i   (req_addr),
        .write_i  (req_write),
        .wdata_i  (req_wdata),
        .done_o   (done),
        .rdata_o  (rdata),
        .slverr_o (slverr),
        .apb      (apb)
    );

    assign sample_valid = sample_valid_q;
    assign sample_data  = sample_data_q;
    assign sample_ch    = sample_ch_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_adc_apb_sampler.sv
// Directed bench for adc_apb_sampler: a behavioural ADC slave answers the bus,
// monitors log transfers and strobes, and one initial block steps the scenarios.
module tb_adc_apb_sampler;

    typedef struct packed {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct packed {
        logic [3:0]  ch;
        logic [31:0] data;
    } sample_t;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] period = 16'd0;
    logic        sample_valid, err, overrun, busy;
    logic [31:0] sample_data;
    logic [3:0]  sample_ch;
    logic [1:0]  err_code;

    adc_apb_sampler_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

    adc_apb_sampler #(.NUM_CH(4)) dut (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .enable       (enable),
        .period       (period),
        .apb          (bus.master),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ch    (sample_ch),
        .err          (err),
        .err_code     (err_code),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 PCLK = ~PCLK;

    // Slave behaviour knobs
    int          wait_states  = 0;
    int          stat_done_on = 3;
    logic [31:0] meas_val     = 32'h0000_0ABC;
    logic        slverr_en    = 1'b0;
    logic [11:0] slverr_addr  = 12'h000;

    int          wcnt = 0;
    int          stat_reads = 0;
    logic [31:0] amux = '0;

    // Observations
    xfer_t       xlog[$];
    sample_t     samples[$];
    int          err_cnt = 0, ovr_cnt = 0, stab_viol = 0, b2b_viol = 0;
    logic        err_busy = 1'b0;
    logic        last_edge_done = 1'b0;
    logic [44:0] setup_vals = '0;

    int vectors = 0;
    int miscompares = 0;

    always @(negedge PCLK) begin
        if (!PRESETn) begin
            wcnt = 0;
            bus.PREADY = 1'b0;
            bus.PSLVERR = 1'b0;
            bus.PRDATA = '0;
        end else if (bus.PSEL && bus.PENABLE) begin
            if (wcnt < wait_states) begin
                wcnt++;
                bus.PREADY = 1'b0;
            end else begin
                wcnt = 0;
                bus.PREADY = 1'b1;
                bus.PSLVERR = slverr_en && (bus.PADDR == slverr_addr);
                bus.PRDATA = '0;
                if (bus.PWRITE) begin
                    if (bus.PADDR == 12'h00C) begin
                        amux = bus.PWDATA;
                        stat_reads = 0;
                    end
                end else if (bus.PADDR == 12'h000) begin
                    stat_reads++;
                    bus.PRDATA = (stat_done_on != 0 && stat_reads >= stat_done_on) ? 32'd1 : 32'd0;
                end else if (bus.PADDR == 12'h004) begin
                    bus.PRDATA = meas_val + amux;
                end
            end
        end else begin
            bus.PREADY = 1'b0;
            bus.PSLVERR = 1'b0;
            bus.PRDATA = '0;
        end
    end

    always @(posedge PCLK) begin
        last_edge_done = PRESETn && bus.PSEL && bus.PENABLE && bus.PREADY;
        if (last_edge_done) xlog.push_back({bus.PWRITE, bus.PADDR, bus.PWDATA});
    end

    always @(negedge PCLK) begin
        if (PRESETn) begin
            if (sample_valid) samples.push_back({sample_ch, sample_data});
            if (err) begin
                err_cnt++;
                err_busy = busy;
            end
            if (overrun) ovr_cnt++;
            if (bus.PSEL && !bus.PENABLE) begin
                setup_vals = {bus.PWRITE, bus.PADDR, bus.PWDATA};
                if (last_edge_done) b2b_viol++;
            end else if (bus.PSEL && bus.PENABLE &&
                         {bus.PWRITE, bus.PADDR, bus.PWDATA} != setup_vals) begin
                stab_viol++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic xfer_t xf(input logic wr, input logic [11:0] a, input logic [31:0] d);
        return {wr, a, d};
    endfunction

    task automatic do_reset();
        PRESETn = 1'b0;
        enable  = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        xlog.delete();
        samples.delete();
        err_cnt = 0; ovr_cnt = 0; stab_viol = 0; b2b_viol = 0;
        err_busy = 1'b0; stat_reads = 0;
        wait_states = 0; stat_done_on = 1; meas_val = 32'h0000_0ABC;
        slverr_en = 1'b0; slverr_addr = 12'h000;
    endtask

    task automatic start(input logic [15:0] p);
        period = p;
        enable = 1'b1;
        @(negedge PCLK);
        PRESETn = 1'b1;
    endtask

    task automatic wait_samples(input int n, input int budget, input string tag);
        int k = 0;
        while (samples.size() < n && k < budget) begin
            @(negedge PCLK);
            k++;
        end
        check(tag, 64'(samples.size() >= n), 64'd1);
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        int k = 0;
        while (xlog.size() < n && k < budget) begin
            @(negedge PCLK);
            k++;
        end
        check(tag, 64'(xlog.size() >= n), 64'd1);
    endtask

    task automatic wait_err(input int budget, input string tag);
        int k = 0;
        while (err_cnt == 0 && k < budget) begin
            @(negedge PCLK);
            k++;
        end
        check(tag, 64'(err_cnt != 0), 64'd1);
    endtask

    task automatic check_nominal_log(input string tag);
        xfer_t exp_x[6];
        exp_x[0] = xf(1'b1, 12'h00C, 32'd0);
        exp_x[1] = xf(1'b1, 12'h010, 32'd1);
        exp_x[2] = xf(1'b0, 12'h000, 32'd0);
        exp_x[3] = xf(1'b0, 12'h000, 32'd0);
        exp_x[4] = xf(1'b0, 12'h000, 32'd0);
        exp_x[5] = xf(1'b0, 12'h004, 32'd0);
        check({tag, "_len"}, 64'(xlog.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("%s_x%0d", tag, i), 64'(xlog[i]), 64'(exp_x[i]));
    endtask

    initial begin
        int meas_reads;

        // Reset state
        #12;
        check("rst_bus", 64'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR}), 64'd0);
        check("rst_pwdata", 64'(bus.PWDATA), 64'd0);
        check("rst_out", 64'({sample_valid, sample_data, sample_ch, err, err_code, overrun, busy}), 64'd0);

        // Nominal: done on third STATUS read
        do_reset();
        stat_done_on = 3;
        start(16'd99);
        wait_samples(1, 200, "nom_sample_wait");
        check_nominal_log("nom");
        check("nom_sample", 64'(samples[0]), 64'({4'd0, 32'h0000_0ABC}));
        check("nom_no_err", 64'(err_cnt), 64'd0);
        check("nom_gap", 64'(b2b_viol), 64'd0);
        wait_log(7, 300, "nom_next_wait");
        check("nom_next_amux", 64'(xlog[6]), 64'(xf(1'b1, 12'h00C, 32'd1)));

        // Five wait states on every access
        do_reset();
        stat_done_on = 3;
        wait_states = 5;
        start(16'd99);
        wait_samples(1, 400, "ws_sample_wait");
        check_nominal_log("ws");
        check("ws_sample", 64'(samples[0]), 64'({4'd0, 32'h0000_0ABC}));
        check("ws_stable", 64'(stab_viol), 64'd0);
        check("ws_gap", 64'(b2b_viol), 64'd0);
        check("ws_idle", 64'(busy), 64'd0);

        // STATUS never done: poll timeout
        do_reset();
        stat_done_on = 0;
        start(16'd999);
        wait_err(600, "to_err_wait");
        check("to_code", 64'(err_code), 64'(2'b10));
        check("to_polls", 64'(stat_reads), 64'd64);
        check("to_len", 64'(xlog.size()), 64'd66);
        meas_reads = 0;
        foreach (xlog[i]) if (!xlog[i].wr && xlog[i].addr == 12'h004) meas_reads++;
        check("to_no_meas", 64'(meas_reads), 64'd0);
        check("to_no_sample", 64'(samples.size()), 64'd0);
        check("to_idle_at_err", 64'(err_busy), 64'd0);
        wait_log(67, 1500, "to_next_wait");
        check("to_next_amux", 64'(xlog[66]), 64'(xf(1'b1, 12'h00C, 32'd1)));

        // PSLVERR on the trigger write
        do_reset();
        slverr_en = 1'b1;
        slverr_addr = 12'h010;
        start(16'd999);
        wait_err(100, "se_err_wait");
        check("se_idle_at_err", 64'(err_busy), 64'd0);
        repeat (10) @(negedge PCLK);
        check("se_code", 64'(err_code), 64'(2'b01));
        check("se_len", 64'(xlog.size()), 64'd2);
        check("se_trig", 64'(xlog[1]), 64'(xf(1'b1, 12'h010, 32'd1)));
        check("se_no_stat", 64'(stat_reads), 64'd0);
        check("se_errs", 64'(err_cnt), 64'd1);

        // Back-to-back period with a slow slave: overrun and channel wrap
        do_reset();
        wait_states = 2;
        meas_val = 32'h0000_0100;
        start(16'd0);
        wait_samples(5, 800, "wrap_wait");
        for (int i = 0; i < 5; i++)
            check($sformatf("wrap_s%0d", i), 64'(samples[i]),
                  64'({4'(i % 4), 32'h0000_0100 + 32'(i % 4)}));
        check("wrap_overrun", 64'(ovr_cnt != 0), 64'd1);

        // Reset asserted during an ACCESS phase
        do_reset();
        wait_states = 5;
        start(16'd99);
        begin
            int k = 0;
            while (!(bus.PSEL && bus.PENABLE) && k < 50) begin
                @(negedge PCLK);
                k++;
            end
            check("mr_access_seen", 64'(bus.PSEL && bus.PENABLE), 64'd1);
        end
        #2 PRESETn = 1'b0;
        #1;
        check("mr_async_drop", 64'({bus.PSEL, bus.PENABLE, busy}), 64'd0);
        @(negedge PCLK);
        xlog.delete();
        samples.delete();
        PRESETn = 1'b1;
        wait_log(1, 100, "mr_first_wait");
        check("mr_first_amux", 64'(xlog[0]), 64'(xf(1'b1, 12'h00C, 32'd0)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adc_apb_sampler.md
Name: adc_apb_sampler

Overview:
APB initiator that autonomously drives the ADC APB slave: selects a channel, triggers a conversion, polls status, and reads the measurement.
- Round-robins over NUM_CH analog channels at a programmable sample period.
- Presents each result as a one-cycle sample strobe with its channel tag.
- Sits between a small control source (tie-offs or a config register) and the ADC peripheral slot on the APB bus.

Parameters:
ADDR_WIDTH, 12, APB address width
DATA_WIDTH, 32, APB data width
NUM_CH, 4, number of AMUX channels scanned (1..16)
PERIOD_W, 16, width of sample-period counter
MAX_POLLS, 64, maximum STATUS reads before timeout
STATUS_ADDR, 12'h000, ADC status register byte address
MEAS_ADDR, 12'h004, ADC measurement register byte address
AMUX_ADDR, 12'h00C, ADC AMUX select register byte address
TRIG_ADDR, 12'h010, ADC trigger register byte address

Ports:
PCLK  in  1  clock; all logic rising-edge
PRESETn  in  1  asynchronous active-low reset
enable  in  1  level; permits new sample sequences
period  in  PERIOD_W  cycles between sequence starts, minus 1; 0 means back-to-back
PSEL  out  1  APB select
PENABLE  out  1  APB access phase
PWRITE  out  1  APB direction, 1 = write
PADDR  out  ADDR_WIDTH  APB address
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error, sampled only when PREADY=1 in access phase
sample_valid  out  1  one-cycle strobe; new result available
sample_data  out  DATA_WIDTH  measurement word, held until next strobe
sample_ch  out  4  channel of sample_data
err  out  1  one-cycle strobe; sequence aborted
err_code  out  2  01 = PSLVERR, 10 = poll timeout; held until next err
overrun  out  1  one-cycle strobe; period tick arrived while busy
busy  out  1  sequence in progress

Behaviour:
Clock and reset
- Single clock PCLK; reset PRESETn is asynchronous, active-low.
- Reset values: every output 0, FSM in IDLE, channel index 0, period counter loaded with 0.

APB protocol
- Every transfer is SETUP (PSEL=1, PENABLE=0) for one cycle, then ACCESS (PSEL=1, PENABLE=1).
- ACCESS is held for as long as PREADY=0; there is no wait-state limit.
- PADDR, PWRITE and PWDATA are stable from SETUP until the ACCESS cycle with PREADY=1.
- After that completing cycle: PSEL=0 and PENABLE=0 for at least one cycle. There are no back-to-back transfers.
- PWDATA=0 on reads.

Period timer
- Down-counter, reloads `period` when it reaches 0 (tick).
- Free-running while enable=1; held at the reload value while enable=0.
- Tick in IDLE with enable=1 starts a sequence.
- Tick while busy: pulse overrun; the tick is dropped.

FSM states, in order
- IDLE
- W_AMUX: write PWDATA = zero-extended channel index
- W_TRIG: write PWDATA = 1
- R_STAT: read; PRDATA[0]=1 means done
- GAP: one idle cycle between status reads
- R_MEAS: read
- Each bus state contains a SETUP/ACCESS phase bit.

Transitions
- R_STAT with done=1 goes to R_MEAS.
- R_STAT with done=0 goes to GAP, then back to R_STAT.
- Poll counter increments per STATUS read. If MAX_POLLS reads all return 0: err, err_code=10, go to IDLE.
- R_MEAS completion:
  - latch PRDATA into sample_data and the channel into sample_ch;
  - sample_valid=1 in the following cycle;
  - go to IDLE.
- PSLVERR=1 on any completing ACCESS: err, err_code=01, go to IDLE immediately. No further transfers in that sequence.

Channel index and status
- Channel index advances (wraps NUM_CH-1 to 0) at the end of every sequence, whether it succeeded or aborted.
- busy = FSM not IDLE.

Boundary conditions
- enable deasserted mid-sequence: the current sequence completes normally.
- Reset mid-transfer: PSEL and PENABLE drop asynchronously to 0.
- `period` changes take effect at the next reload.
- NUM_CH=1: channel is always 0.

Decomposition:
- Shared package holds:
  - the FSM state enum;
  - err_code constants ERR_SLVERR = 2'b01, ERR_TIMEOUT = 2'b10;
  - the STATUS done-bit index (0);
  - default register offsets. These are shared with the ADC slave wrapper so both ends agree.
- One natural sub-module: apb_master_port. It takes a request (addr, write, wdata, req) and returns done, rdata and slverr, and owns the SETUP/ACCESS sequencing and the PREADY wait.
- The sampler FSM, period timer and channel counter stay in the top level.

Test Plan:
- Nominal sequence: enable=1, period=99, NUM_CH=4, responder PREADY=1 always, STATUS returns 1 on the 3rd read, MEAS=32'h0000_0ABC.
  Required bus order: W 0x00C=0, W 0x010=1, R 0x000 ×3 with GAP cycles between, R 0x004.
  Required outputs: sample_valid pulse with sample_data=0xABC, sample_ch=0; next sequence writes AMUX=1.
- Wait states: PREADY low for 5 cycles on every ACCESS -> PADDR, PWRITE and PWDATA stable throughout; sequence result identical to the nominal case.
- Timeout: STATUS always 0 -> exactly 64 STATUS reads, err with err_code=10, no MEAS read, next sequence uses the incremented channel.
- PSLVERR: PSLVERR=1 on the TRIG write -> err with err_code=01, no STATUS read, FSM back in IDLE the next cycle.
- Overrun and wrap: period=0 with slow slave -> overrun pulses; channel sequence 0,1,2,3,0 observed over 5 samples.
- Reset mid-ACCESS: PRESETn low during ACCESS -> PSEL=0 and PENABLE=0 asynchronously; after release the first write is AMUX=0.
